// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART 8N1 receiver followed by a small first-word-fall-through FIFO.
//   The rxd line is synchronised, each character is deframed by a four-state
//   FSM that samples at mid-bit, and good bytes are queued for the consumer.
//
// Parameters
//   DIV    clock cycles per bit (even, >= 8)
//   DEPTH  FIFO entries (power of two, >= 2)
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-low reset, clears all state
//   rxd     in   asynchronous UART line, idles high
//   d_rx    out  head-of-FIFO byte, meaningful while vld_rx=1
//   vld_rx  out  FIFO non-empty
//   rdy_rx  in   consumer ready; a pop happens when vld_rx & rdy_rx
//   ferr    out  one-cycle pulse: stop bit sampled low, byte discarded
//   ovf     out  one-cycle pulse: byte completed into a full FIFO, dropped
//   busy    out  receiver FSM is not idle
module uart_rx_fifo #(
  parameter int DIV   = 868,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] d_rx,
  output logic       vld_rx,
  input  logic       rdy_rx,
  output logic       ferr,
  output logic       ovf,
  output logic       busy
);

  localparam int TW = $clog2(DIV);
  localparam int AW = $clog2(DEPTH);
  localparam logic [TW-1:0] T_HALF   = TW'(DIV / 2 - 1);
  localparam logic [TW-1:0] T_FULL   = TW'(DIV - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser; both flops reset to the idle line level so that reset
  // release never looks like a start edge.
  // ---------------------------------------------------------------------------
  logic rxd_meta_q, rxd_s_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make the two flops a real two-stage
      // shift; blocking ones would collapse them into a single flop.
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [2:0]      bcnt_q, bcnt_d;
  logic [7:0]      sh_q, sh_d;
  logic            push;
  logic            ferr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    push    = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        bcnt_d = '0;
        if (!rxd_s_q) state_d = S_START;
      end

      // Wait half a bit and re-check the line to reject short glitches.
      S_START: begin
        if (tcnt_q == T_HALF) begin
          tcnt_d  = '0;
          state_d = rxd_s_q ? S_IDLE : S_DATA;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      // Sampling is now aligned to mid-bit; take one sample per bit, LSB first.
      S_DATA: begin
        if (tcnt_q == T_FULL) begin
          tcnt_d = '0;
          sh_d   = {rxd_s_q, sh_q[7:1]};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = S_STOP;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      // Leave at mid stop bit so a start edge immediately after it is caught.
      S_STOP: begin
        if (tcnt_q == T_FULL) begin
          tcnt_d  = '0;
          state_d = S_IDLE;
          if (rxd_s_q) push   = 1'b1;
          else         ferr_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  // ---------------------------------------------------------------------------
  // FWFT FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ferr_q, ovf_q;
  logic          full, pop, wr_en, ovf_d;

  assign vld_rx = (count_q != '0);
  assign d_rx   = mem_q[rd_ptr_q];
  assign full   = (count_q == FULL_CNT);
  assign pop    = vld_rx & rdy_rx;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then.
  assign wr_en  = push & (~full | pop);
  assign ovf_d  = push & full & ~pop;

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the storage is cleared on reset on purpose: d_rx shows
      // mem[rd_ptr] directly and must read 0 while in reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= sh_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ferr = ferr_q;
  assign ovf  = ovf_q;

endmodule
